key_cmd_decoder: RTL and testbench
==================================

KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning event FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port key_data  input  8  raw PS/2 scan-code byte from the keyboard receiver.
REQ-005 SHALL have port key_valid  input  1  one-cycle strobe qualifying key_data.
REQ-006 SHALL have port p1_dir / p2_dir  output  2 each  current direction (0 up, 1 down, 2 left, 3 right).
REQ-007 SHALL have port p1_move / p2_move  output  1 each  high while any direction key of that player is held.
REQ-008 SHALL have port ev_data  output  4  {player, code[2:0]}; player 0 = P1, 1 = P2; code 0-3 = direction press, 4 = fire press.
REQ-009 SHALL have port ev_valid  output  1; port ev_ready  input  1; valid/ready event stream to game logic.
REQ-010 SHALL have port ev_overflow  output  1  sticky flag, set when an event is dropped.

Function
REQ-011 Key map SHALL be P1 W=1D, S=1B, A=1C, D=23, fire J=3B (non-extended); P2 up E0 75, down E0 72, left E0 6B, right E0 74, fire Enter=5A (non-extended).
REQ-012 Parser FSM SHALL have states IDLE, EXT, BRK, EXT_BRK and advance only on cycles where key_valid is high.
REQ-013 Transitions SHALL be: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; any state+E0 other than IDLE->EXT (malformed sequence resync); any other byte->decode with current ext/brk flags, then->IDLE.
REQ-014 Byte E1 and unmapped codes SHALL be ignored (no state bit change) and the FSM SHALL return to IDLE.
REQ-015 A mapped make code SHALL set that key's held bit; a mapped break code SHALL clear it; a break SHALL generate no event.
REQ-016 Held bits and pN_move SHALL update in the cycle after the decoding key_valid (latency 1).
REQ-017 pN_dir SHALL equal the most recently pressed still-held direction; when it is released, pN_dir SHALL take the highest-priority still-held direction (up>down>left>right), else hold its last value.
REQ-018 Each mapped make code SHALL push one event; ev_valid SHALL rise the cycle after the decoding key_valid when the FIFO was empty.
REQ-019 Event transfer SHALL occur on cycles where ev_valid and ev_ready are both high; ev_data SHALL be stable while ev_valid is high and ev_ready is low.
REQ-020 Push into a full FIFO SHALL be dropped and set ev_overflow, except when a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-021 Push and pop into a non-full, non-empty FIFO in the same cycle SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-022 While rst is high: FSM->IDLE, all held bits 0, pN_dir=0, pN_move=0, FIFO empty, ev_valid=0, ev_data=0, ev_overflow=0.
REQ-023 Reset asserted mid-sequence (after E0 or F0) SHALL discard the partial sequence; the first byte after reset SHALL be parsed from IDLE.

Configuration
REQ-024 Macro KEY_TYPEMATIC_FILTER_EN: when defined, a make code for a key whose held bit is already set (typematic repeat) SHALL push no event; when undefined, every make code SHALL push an event.
REQ-025 Held-bit and direction behaviour SHALL be identical with and without KEY_TYPEMATIC_FILTER_EN.

Structure
REQ-026 Shared package tank_key_pkg SHALL hold scan-code constants, prefix constants E0/F0/E1, event code constants, and parser state encoding.
REQ-027 The event FIFO SHALL be a sub-module key_event_fifo (parameter FIFO_DEPTH, width 4, registered count, sticky overflow).

Verification
REQ-028 Bytes 1D, F0 1D -> event {0,0}; p1_move 1 then 0; p1_dir=0.
REQ-029 Bytes E0 74, then 1C -> events {1,3} then {0,2}; p2_dir=3, p1_dir=2, both move=1.
REQ-030 P1 holds W then D, releases D (1D, 23, F0 23) -> p1_dir 0->3->0, p1_move stays 1.
REQ-031 With ev_ready=0 and FIFO_DEPTH=4, send 3B five times (filter undefined) -> 4 events stored, ev_overflow=1; with filter defined -> 1 event, ev_overflow=0.
REQ-032 Bytes E0, then rst pulse, then 75 -> no P2 event; 75 unmapped non-extended, FSM in IDLE, no output change.
REQ-033 FIFO full, ev_ready=1 with simultaneous new make code -> pop and push both accepted, occupancy stays 4, ev_overflow=0.

Source files
------------

// File: rtl/tank_key_pkg.sv
// Purpose: shared scan-code, prefix, event-code and parser-state definitions for the key decoder.
// Latency: none (constants, types and pure functions only).
// Backpressure: not applicable.
package tank_key_pkg;

    // Scan-code prefixes: extended, break, pause sequence start
    localparam logic [7:0] SC_PFX_EXT   = 8'hE0;
    localparam logic [7:0] SC_PFX_BRK   = 8'hF0;
    localparam logic [7:0] SC_PFX_PAUSE = 8'hE1;

    // Player 1: WASD + J (non-extended)
    localparam logic [7:0] SC_P1_UP    = 8'h1D;
    localparam logic [7:0] SC_P1_DOWN  = 8'h1B;
    localparam logic [7:0] SC_P1_LEFT  = 8'h1C;
    localparam logic [7:0] SC_P1_RIGHT = 8'h23;
    localparam logic [7:0] SC_P1_FIRE  = 8'h3B;

    // Player 2: arrow keys (extended) + main Enter (non-extended)
    localparam logic [7:0] SC_P2_UP    = 8'h75;
    localparam logic [7:0] SC_P2_DOWN  = 8'h72;
    localparam logic [7:0] SC_P2_LEFT  = 8'h6B;
    localparam logic [7:0] SC_P2_RIGHT = 8'h74;
    localparam logic [7:0] SC_P2_FIRE  = 8'h5A;

    // Event codes; direction codes double as the pN_dir encoding
    localparam logic [2:0] EV_UP    = 3'd0;
    localparam logic [2:0] EV_DOWN  = 3'd1;
    localparam logic [2:0] EV_LEFT  = 3'd2;
    localparam logic [2:0] EV_RIGHT = 3'd3;
    localparam logic [2:0] EV_FIRE  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_e;

    typedef struct packed {
        logic       hit;
        logic       player;
        logic [2:0] code;
    } key_hit_t;

    // Map a final scan-code byte (with its extended flag) to player/key
    function automatic key_hit_t decode_key(input logic [7:0] sc, input logic ext);
        key_hit_t r;
        r     = '0;
        r.hit = 1'b1;
        if (!ext) begin
            case (sc)
                SC_P1_UP:    begin r.player = 1'b0; r.code = EV_UP;    end
                SC_P1_DOWN:  begin r.player = 1'b0; r.code = EV_DOWN;  end
                SC_P1_LEFT:  begin r.player = 1'b0; r.code = EV_LEFT;  end
                SC_P1_RIGHT: begin r.player = 1'b0; r.code = EV_RIGHT; end
                SC_P1_FIRE:  begin r.player = 1'b0; r.code = EV_FIRE;  end
                SC_P2_FIRE:  begin r.player = 1'b1; r.code = EV_FIRE;  end
                default:     r.hit = 1'b0;
            endcase
        end else begin
            case (sc)
                SC_P2_UP:    begin r.player = 1'b1; r.code = EV_UP;    end
                SC_P2_DOWN:  begin r.player = 1'b1; r.code = EV_DOWN;  end
                SC_P2_LEFT:  begin r.player = 1'b1; r.code = EV_LEFT;  end
                SC_P2_RIGHT: begin r.player = 1'b1; r.code = EV_RIGHT; end
                default:     r.hit = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Highest-priority held direction (up > down > left > right), else keep last
    function automatic logic [1:0] pick_dir(input logic [3:0] held, input logic [1:0] last);
        logic [1:0] r;
        r = last;
        if (held[0])      r = 2'd0;
        else if (held[1]) r = 2'd1;
        else if (held[2]) r = 2'd2;
        else if (held[3]) r = 2'd3;
        return r;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Purpose: small event FIFO (4-bit entries) with registered count and sticky overflow flag.
// Latency: one cycle from push to vld_o when empty; head data is combinational from storage.
// Backpressure: push into a full FIFO is dropped (sets overflow) unless a pop happens in the same cycle.
module key_event_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [3:0] push_dat_i,
    input  logic       pop_rdy_i,
    output logic       vld_o,
    output logic [3:0] dat_o,
    output logic       overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [3:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          full, pop, push_ok;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign vld_o   = (count_q != '0);
    assign pop     = vld_o && pop_rdy_i;
    // A simultaneous pop frees the slot the push needs
    assign push_ok = push_i && (!full || pop);

    assign dat_o      = vld_o ? mem_q[rd_ptr_q] : 4'h0;
    assign overflow_o = ovf_q;

    // Storage write; contents are don't-care until counted valid
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

    // Pointers (wrap naturally, depth is a power of two), occupancy and overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (!push_ok && pop) count_q <= count_q - 1'b1;
            if (push_i && !push_ok)   ovf_q <= 1'b1;
        end
    end
endmodule

// File: rtl/key_cmd_decoder.sv
// Purpose: PS/2 scan-code parser producing two-player tank direction/move state and a key event stream.
// Latency: held bits, dir/move and ev_valid (FIFO empty) update one cycle after the decoding key_valid.
// Backpressure: ev_valid/ev_ready stream buffered by key_event_fifo; drops set sticky ev_overflow.
// Build option: define KEY_TYPEMATIC_FILTER_EN to suppress events for typematic repeats of held keys.
module key_cmd_decoder
    import tank_key_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic       p1_move,
    output logic       p2_move,
    output logic [3:0] ev_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       ev_overflow
);
    parse_state_e    state_q, state_d;
    key_hit_t        hit;
    logic            dec_vld, dec_brk;
    logic [1:0][4:0] held_q, held_d;
    logic [1:0][1:0] dir_q, dir_d;
    logic            push;
    logic [3:0]      push_dat;

    // Parser state register; reset drops any partial prefix sequence
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Parser next state and decode strobe for the final byte of a sequence
    always_comb begin
        state_d = state_q;
        dec_vld = 1'b0;
        dec_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
        hit     = decode_key(key_data, (state_q == ST_EXT) || (state_q == ST_EXT_BRK));
        if (key_valid) begin
            if (key_data == SC_PFX_EXT) begin
                // E0 from anywhere restarts an extended sequence
                state_d = ST_EXT;
            end else if (key_data == SC_PFX_BRK && state_q == ST_IDLE) begin
                state_d = ST_BRK;
            end else if (key_data == SC_PFX_BRK && state_q == ST_EXT) begin
                state_d = ST_EXT_BRK;
            end else if (key_data == SC_PFX_PAUSE) begin
                // Pause sequences are not used; just resync
                state_d = ST_IDLE;
            end else begin
                state_d = ST_IDLE;
                dec_vld = hit.hit;
            end
        end
    end

    // Held-key, direction and event-push decisions for a decoded key
    always_comb begin
        held_d   = held_q;
        dir_d    = dir_q;
        push     = 1'b0;
        push_dat = 4'h0;
        if (dec_vld) begin
            push_dat = {hit.player, hit.code};
            if (!dec_brk) begin
                held_d[hit.player][hit.code] = 1'b1;
                if (hit.code != EV_FIRE) dir_d[hit.player] = hit.code[1:0];
`ifdef KEY_TYPEMATIC_FILTER_EN
                push = !held_q[hit.player][hit.code];
`else
                push = 1'b1;
`endif
            end else begin
                held_d[hit.player][hit.code] = 1'b0;
                // Releasing the active direction falls back to the best still-held one
                if (hit.code != EV_FIRE && dir_q[hit.player] == hit.code[1:0])
                    dir_d[hit.player] = pick_dir(held_d[hit.player][3:0], dir_q[hit.player]);
            end
        end
    end

    // Held-key and direction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= '0;
            dir_q  <= '0;
        end else begin
            held_q <= held_d;
            dir_q  <= dir_d;
        end
    end

    assign p1_dir  = dir_q[0];
    assign p2_dir  = dir_q[1];
    assign p1_move = |held_q[0][3:0];
    assign p2_move = |held_q[1][3:0];

    key_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_rdy_i  (ev_ready),
        .vld_o      (ev_valid),
        .dat_o      (ev_data),
        .overflow_o (ev_overflow)
    );
endmodule

// File: tb/tb_key_cmd_decoder.sv
// Purpose: self-checking bench for key_cmd_decoder (behavioural model + directed scan-code sequences).
// Latency: model tracks one-cycle output latency; outputs compared every falling edge.
// Backpressure: ev_ready driven directly to exercise stalls, full FIFO and simultaneous push/pop.
module tb_key_cmd_decoder;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_data;
    logic       key_valid;
    logic [1:0] p1_dir, p2_dir;
    logic       p1_move, p2_move;
    logic [3:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    key_cmd_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_data    (key_data),
        .key_valid   (key_valid),
        .p1_dir      (p1_dir),
        .p2_dir      (p2_dir),
        .p1_move     (p1_move),
        .p2_move     (p2_move),
        .ev_data     (ev_data),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_overflow (ev_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Key table: returns player*8 + code, or -1 when the byte is not a mapped key
    function automatic int lookup(input bit ext, input logic [7:0] sc);
        case ({ext, sc})
            9'h01D: return 0;
            9'h01B: return 1;
            9'h01C: return 2;
            9'h023: return 3;
            9'h03B: return 4;
            9'h05A: return 12;
            9'h175: return 8;
            9'h172: return 9;
            9'h16B: return 10;
            9'h174: return 11;
            default: return -1;
        endcase
    endfunction

    // Model state
    bit         started = 1'b0;
    bit         m_ext, m_brk, m_ovf;
    bit         m_held [2][5];
    int         m_dir  [2];
    logic [3:0] m_q    [$];

    always @(posedge clk) begin : model
        int  k;
        int  pl, cd;
        bit  pop, push, found;
        started = 1'b1;
        if (rst) begin
            m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
            foreach (m_held[i, j]) m_held[i][j] = 1'b0;
            m_dir[0] = 0; m_dir[1] = 0;
            m_q.delete();
        end else begin
            pop  = (m_q.size() != 0) && ev_ready;
            push = 1'b0;
            k    = -1;
            if (key_valid) begin
                if (key_data == 8'hE0) begin
                    m_ext = 1'b1; m_brk = 1'b0;
                end else if (key_data == 8'hF0 && !m_brk) begin
                    m_brk = 1'b1;
                end else begin
                    k = lookup(m_ext, key_data);
                    if (k >= 0) begin
                        pl = k / 8;
                        cd = k % 8;
                        if (!m_brk) begin
`ifdef KEY_TYPEMATIC_FILTER_EN
                            push = !m_held[pl][cd];
`else
                            push = 1'b1;
`endif
                            m_held[pl][cd] = 1'b1;
                            if (cd < 4) m_dir[pl] = cd;
                        end else begin
                            m_held[pl][cd] = 1'b0;
                            if (cd < 4 && m_dir[pl] == cd) begin
                                found = 1'b0;
                                for (int d = 0; d < 4; d++)
                                    if (!found && m_held[pl][d]) begin
                                        m_dir[pl] = d;
                                        found = 1'b1;
                                    end
                            end
                        end
                    end
                    m_ext = 1'b0; m_brk = 1'b0;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(4'(k));
                else m_ovf = 1'b1;
            end
        end
    end

    // Compare every cycle once the model has seen a clock edge
    always @(negedge clk) begin
        if (started) begin
            check("p1_dir", 32'(p1_dir), 32'(m_dir[0]));
            check("p2_dir", 32'(p2_dir), 32'(m_dir[1]));
            check("p1_move", 32'(p1_move),
                  32'(m_held[0][0] | m_held[0][1] | m_held[0][2] | m_held[0][3]));
            check("p2_move", 32'(p2_move),
                  32'(m_held[1][0] | m_held[1][1] | m_held[1][2] | m_held[1][3]));
            check("ev_valid", 32'(ev_valid), 32'(m_q.size() != 0));
            check("ev_data", 32'(ev_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
            check("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        key_data  = b;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(output int n, output logic [3:0] last);
        n    = 0;
        last = 4'h0;
        ev_ready = 1'b1;
        for (int i = 0; i < 16 && ev_valid; i++) begin
            n++;
            last = ev_data;
            @(negedge clk);
        end
        check("drain_empty", 32'(ev_valid), 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int         n;
        logic [3:0] last;
        rst = 1'b1; key_valid = 1'b0; key_data = 8'h00; ev_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ev_valid", 32'(ev_valid), 32'h0);
        check("rst_ev_data", 32'(ev_data), 32'h0);
        check("rst_p1_dir", 32'(p1_dir), 32'h0);
        check("rst_ovf", 32'(ev_overflow), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // W press/release
        send_byte(8'h1D);
        check("w_move", 32'(p1_move), 32'h1);
        check("w_ev_valid", 32'(ev_valid), 32'h1);
        check("w_ev_data", 32'(ev_data), 32'h0);
        send_byte(8'hF0); send_byte(8'h1D);
        check("w_rel_move", 32'(p1_move), 32'h0);
        check("w_rel_dir", 32'(p1_dir), 32'h0);

        // P2 right (extended) then P1 left, stalled consumer
        ev_ready = 1'b0;
        send_byte(8'hE0); send_byte(8'h74);
        check("p2r_dir", 32'(p2_dir), 32'h3);
        check("p2r_move", 32'(p2_move), 32'h1);
        check("p2r_ev", 32'(ev_data), 32'hB);
        send_byte(8'h1C);
        check("p1l_dir", 32'(p1_dir), 32'h2);
        check("p1l_move", 32'(p1_move), 32'h1);
        check("stall_ev", 32'(ev_data), 32'hB);
        ev_ready = 1'b1;
        @(negedge clk);
        check("second_ev", 32'(ev_data), 32'h2);
        @(negedge clk);
        check("empty_after", 32'(ev_valid), 32'h0);
        send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check("p2_released", 32'(p2_move), 32'h0);
        check("p2_dir_hold", 32'(p2_dir), 32'h3);

        // Hold W then D, release D
        send_byte(8'h1D);
        send_byte(8'h23);
        check("wd_dir", 32'(p1_dir), 32'h3);
        send_byte(8'hF0); send_byte(8'h23);
        check("wd_back", 32'(p1_dir), 32'h0);
        check("wd_move", 32'(p1_move), 32'h1);
        send_byte(8'hF0); send_byte(8'h1D);

        // Priority fallback: down, left, right held; release right -> down
        send_byte(8'h1B); send_byte(8'h1C); send_byte(8'h23);
        send_byte(8'hF0); send_byte(8'h23);
        check("prio_dir", 32'(p1_dir), 32'h1);
        send_byte(8'hF0); send_byte(8'h1C);
        check("noncur_rel", 32'(p1_dir), 32'h1);
        send_byte(8'hF0); send_byte(8'h1B);
        check("none_held", 32'(p1_move), 32'h0);

        // Typematic fire with stalled consumer
        pulse_reset();
        ev_ready = 1'b0;
        repeat (5) send_byte(8'h3B);
`ifdef KEY_TYPEMATIC_FILTER_EN
        check("typ_ovf", 32'(ev_overflow), 32'h0);
        drain(n, last);
        check("typ_count", 32'(n), 32'd1);
`else
        check("typ_ovf", 32'(ev_overflow), 32'h1);
        drain(n, last);
        check("typ_count", 32'(n), 32'd4);
`endif
        check("typ_last", 32'(last), 32'h4);

        // Full FIFO with simultaneous pop and push
        pulse_reset();
        ev_ready = 1'b0;
        repeat (4) begin
            send_byte(8'h3B); send_byte(8'hF0); send_byte(8'h3B);
        end
        check("full_ovf", 32'(ev_overflow), 32'h0);
        ev_ready = 1'b1;
        send_byte(8'h1B);
        ev_ready = 1'b0;
        check("pp_ovf", 32'(ev_overflow), 32'h0);
        check("pp_dir", 32'(p1_dir), 32'h1);
        drain(n, last);
        check("pp_count", 32'(n), 32'd4);
        check("pp_last", 32'(last), 32'h1);
        send_byte(8'hF0); send_byte(8'h1B);

        // Reset mid-sequence discards the E0 prefix
        ev_ready = 1'b0;
        send_byte(8'hE0);
        pulse_reset();
        send_byte(8'h75);
        check("rst_seq_p2move", 32'(p2_move), 32'h0);
        check("rst_seq_ev", 32'(ev_valid), 32'h0);
        check("rst_seq_p2dir", 32'(p2_dir), 32'h0);
        send_byte(8'h1D);
        check("idle_after_rst", 32'(ev_data), 32'h0);
        check("idle_ev_valid", 32'(ev_valid), 32'h1);
        send_byte(8'hE1); send_byte(8'h1B);
        check("e1_dir", 32'(p1_dir), 32'h1);
        drain(n, last);
        check("e1_count", 32'(n), 32'd2);
        check("e1_last", 32'(last), 32'h1);

        // Malformed F0 E0 74 resyncs to an extended make
        send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h74);
        check("resync_dir", 32'(p2_dir), 32'h3);
        check("resync_move", 32'(p2_move), 32'h1);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
